ddr3_ram_queue: RTL and testbench

//  Request buffer on the internal 128-bit RAM interface, between the AXI-to-RAM converter
//  (ddr3_axi_pmem) and the DDR3 core (ddr3_core). It queues requests so the AXI side is not

---
 rtl/ddr3_ram_pkg.sv | 20 ++
 rtl/ddr3_ram_fifo.sv | 50 +++++
 rtl/ddr3_ram_queue.sv | 131 +++++++++++++
 tb/tb_ddr3_ram_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ram_pkg.sv
// Shared widths and the request-entry bundle for the 128-bit RAM interface.
// Entry layout: {addr, wr, rd, req_id, wdata} = 193 bits.
package ddr3_ram_pkg;

  localparam int RAM_ADDR_W = 32;
  localparam int RAM_DATA_W = 128;
  localparam int RAM_MASK_W = 16;
  localparam int RAM_ID_W   = 16;

  typedef struct packed {
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_MASK_W-1:0] wr;
    logic                  rd;
    logic [RAM_ID_W-1:0]   id;
    logic [RAM_DATA_W-1:0] data;
  } ram_req_t;

  localparam int RAM_REQ_W = $bits(ram_req_t);

endpackage

// File: rtl/ddr3_ram_fifo.sv
// Generic synchronous FIFO with head-of-queue output.
// Ports: push_i/pop_i, data_i, data_o (head), full_o, empty_o, level_o.
module ddr3_ram_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Extra pointer bit distinguishes full from empty.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ddr3_ram_queue.sv
// Request queue between the AXI-to-RAM converter and the DDR3 core.
// inport_*: upstream requests/responses; outport_*: core side.
module ddr3_ram_queue
  import ddr3_ram_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [RAM_MASK_W-1:0] inport_wr_i,
  input  logic                  inport_rd_i,
  input  logic [RAM_ADDR_W-1:0] inport_addr_i,
  input  logic [RAM_DATA_W-1:0] inport_write_data_i,
  input  logic [RAM_ID_W-1:0]   inport_req_id_i,
  output logic                  inport_accept_o,
  output logic                  inport_ack_o,
  output logic                  inport_error_o,
  output logic [RAM_DATA_W-1:0] inport_read_data_o,
  output logic [RAM_ID_W-1:0]   inport_resp_id_o,
  output logic [RAM_MASK_W-1:0] outport_wr_o,
  output logic                  outport_rd_o,
  output logic [RAM_ADDR_W-1:0] outport_addr_o,
  output logic [RAM_DATA_W-1:0] outport_write_data_o,
  output logic [RAM_ID_W-1:0]   outport_req_id_o,
  input  logic                  outport_accept_i,
  input  logic                  outport_ack_i,
  input  logic                  outport_error_i,
  input  logic [RAM_DATA_W-1:0] outport_read_data_i,
  input  logic [RAM_ID_W-1:0]   outport_resp_id_i
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic                 req_present;
  logic                 xfer;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 full_d;
  logic [LW-1:0]        level;
  logic                 accept_q;
  logic [OW-1:0]        outstanding_q;
  logic [OW-1:0]        outstanding_d;
  ram_req_t             push_req;
  ram_req_t             head;
  logic [RAM_REQ_W-1:0] head_bits;

  assign req_present = (|inport_wr_i) | inport_rd_i;
  assign xfer        = req_present && accept_q;
  assign pop         = outport_accept_i && !empty;

  // A write with a stray read flag is forwarded as a plain write.
  always_comb begin
    push_req      = '0;
    push_req.addr = inport_addr_i;
    push_req.wr   = inport_wr_i;
    push_req.rd   = inport_rd_i && (inport_wr_i == '0);
    push_req.id   = inport_req_id_i;
    push_req.data = inport_write_data_i;
  end

  ddr3_ram_fifo #(
    .WIDTH (RAM_REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (xfer),
    .pop_i   (pop),
    .data_i  (push_req),
    .data_o  (head_bits),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign head = head_bits;

  assign outport_wr_o         = empty ? '0 : head.wr;
  assign outport_rd_o         = !empty && head.rd;
  assign outport_addr_o       = head.addr;
  assign outport_write_data_o = head.data;
  assign outport_req_id_o     = head.id;

  // Next-cycle occupancy state, so accept can be a pure register.
  always_comb begin
    full_d = 1'b0;
    if (full)
      full_d = !pop;
    else
      full_d = xfer && !pop && (level == LW'(DEPTH - 1));
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (xfer && !outport_ack_i)
      outstanding_d = outstanding_q + 1'b1;
    else if (!xfer && outport_ack_i && outstanding_q != '0)
      outstanding_d = outstanding_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      accept_q           <= 1'b1;
      outstanding_q      <= '0;
      inport_ack_o       <= 1'b0;
      inport_error_o     <= 1'b0;
      inport_read_data_o <= '0;
      inport_resp_id_o   <= '0;
    end else begin
      accept_q           <= !full_d &&
                            (outstanding_d < OW'(MAX_OUTSTANDING));
      outstanding_q      <= outstanding_d;
      inport_ack_o       <= outport_ack_i;
      inport_error_o     <= outport_error_i;
      inport_read_data_o <= outport_read_data_i;
      inport_resp_id_o   <= outport_resp_id_i;
    end
  end

  assign inport_accept_o = accept_q;

  // An ack with nothing outstanding means the core lost track of tags.
  ack_without_req: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(outport_ack_i && outstanding_q == '0)
  );

endmodule

// File: tb/tb_ddr3_ram_queue.sv
// Self-checking bench for ddr3_ram_queue: vector table, corner
// sequences and a randomized run against a queue-based model.
module tb_ddr3_ram_queue;
  import ddr3_ram_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [15:0]  inport_wr_i;
  logic         inport_rd_i;
  logic [31:0]  inport_addr_i;
  logic [127:0] inport_write_data_i;
  logic [15:0]  inport_req_id_i;
  logic         inport_accept_o;
  logic         inport_ack_o;
  logic         inport_error_o;
  logic [127:0] inport_read_data_o;
  logic [15:0]  inport_resp_id_o;
  logic [15:0]  outport_wr_o;
  logic         outport_rd_o;
  logic [31:0]  outport_addr_o;
  logic [127:0] outport_write_data_o;
  logic [15:0]  outport_req_id_o;
  logic         outport_accept_i;
  logic         outport_ack_i;
  logic         outport_error_i;
  logic [127:0] outport_read_data_i;
  logic [15:0]  outport_resp_id_i;

  int vec = 0;
  int bad = 0;

  ddr3_ram_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .inport_wr_i          (inport_wr_i),
    .inport_rd_i          (inport_rd_i),
    .inport_addr_i        (inport_addr_i),
    .inport_write_data_i  (inport_write_data_i),
    .inport_req_id_i      (inport_req_id_i),
    .inport_accept_o      (inport_accept_o),
    .inport_ack_o         (inport_ack_o),
    .inport_error_o       (inport_error_o),
    .inport_read_data_o   (inport_read_data_o),
    .inport_resp_id_o     (inport_resp_id_o),
    .outport_wr_o         (outport_wr_o),
    .outport_rd_o         (outport_rd_o),
    .outport_addr_o       (outport_addr_o),
    .outport_write_data_o (outport_write_data_o),
    .outport_req_id_o     (outport_req_id_o),
    .outport_accept_i     (outport_accept_i),
    .outport_ack_i        (outport_ack_i),
    .outport_error_i      (outport_error_i),
    .outport_read_data_i  (outport_read_data_i),
    .outport_resp_id_i    (outport_resp_id_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] wr;
    logic        rd;
    logic [31:0] addr;
    logic        acc;
    logic        e_accept;
    logic [15:0] e_wr;
    logic        e_rd;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    inport_wr_i         = '0;
    inport_rd_i         = 1'b0;
    inport_addr_i       = '0;
    inport_write_data_i = '0;
    inport_req_id_i     = '0;
    outport_accept_i    = 1'b0;
    outport_ack_i       = 1'b0;
    outport_error_i     = 1'b0;
    outport_read_data_i = '0;
    outport_resp_id_i   = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  ram_req_t     mq[$];
  ram_req_t     e;
  int           mout;
  int           n;
  logic         exp_acc;
  logic         present;
  logic         xfer;
  logic         p_ack;
  logic         p_err;
  logic [127:0] p_data;
  logic [15:0]  p_id;
  int           kind;
  int           acc_pct;
  int           ack_pct;

  initial begin
    idle();

    // reset state
    do_reset();
    chk("rst_accept", inport_accept_o, 1'b1);
    chk("rst_wr", outport_wr_o, 16'h0);
    chk("rst_rd", outport_rd_o, 1'b0);
    chk("rst_ack", inport_ack_o, 1'b0);
    chk("rst_err", inport_error_o, 1'b0);
    chk("rst_rdata", inport_read_data_o, 128'h0);
    chk("rst_rid", inport_resp_id_o, 16'h0);

    // single read with delayed ack
    inport_rd_i      = 1'b1;
    inport_addr_i    = 32'h100;
    inport_req_id_i  = 16'h0005;
    outport_accept_i = 1'b1;
    tick();
    chk("rd_vis", outport_rd_o, 1'b1);
    chk("rd_addr", outport_addr_o, 32'h100);
    chk("rd_id", outport_req_id_o, 16'h5);
    inport_rd_i = 1'b0;
    tick();
    chk("rd_popped", outport_rd_o, 1'b0);
    tick();
    chk("rd_noack", inport_ack_o, 1'b0);
    outport_ack_i       = 1'b1;
    outport_read_data_i = {4{32'hDEADBEEF}};
    outport_resp_id_i   = 16'h5;
    tick();
    chk("rd_ack", inport_ack_o, 1'b1);
    chk("rd_data", inport_read_data_o, {4{32'hDEADBEEF}});
    chk("rd_rid", inport_resp_id_o, 16'h5);
    outport_ack_i = 1'b0;
    tick();
    chk("rd_ack_pulse", inport_ack_o, 1'b0);

    // fill, drain in order, then conflict and plain read
    tbl.push_back('{16'hFFFF, 0, 32'h10, 0, 1, 16'hFFFF, 0, 32'h10});
    tbl.push_back('{16'h000F, 0, 32'h20, 0, 1, 16'hFFFF, 0, 32'h10});
    tbl.push_back('{16'hF000, 0, 32'h30, 0, 1, 16'hFFFF, 0, 32'h10});
    tbl.push_back('{16'h0001, 0, 32'h40, 0, 0, 16'hFFFF, 0, 32'h10});
    tbl.push_back('{16'hFFFF, 0, 32'h99, 0, 0, 16'hFFFF, 0, 32'h10});
    tbl.push_back('{16'h0000, 0, 32'h00, 1, 1, 16'h000F, 0, 32'h20});
    tbl.push_back('{16'h0000, 0, 32'h00, 1, 1, 16'hF000, 0, 32'h30});
    tbl.push_back('{16'h0000, 0, 32'h00, 1, 1, 16'h0001, 0, 32'h40});
    tbl.push_back('{16'h0000, 0, 32'h00, 1, 1, 16'h0000, 0, 32'h00});
    tbl.push_back('{16'h00FF, 1, 32'h50, 0, 1, 16'h00FF, 0, 32'h50});
    tbl.push_back('{16'h0000, 0, 32'h00, 1, 1, 16'h0000, 0, 32'h00});
    tbl.push_back('{16'h0000, 1, 32'h60, 0, 1, 16'h0000, 1, 32'h60});
    tbl.push_back('{16'h0000, 0, 32'h00, 1, 1, 16'h0000, 0, 32'h00});
    do_reset();
    foreach (tbl[i]) begin
      inport_wr_i      = tbl[i].wr;
      inport_rd_i      = tbl[i].rd;
      inport_addr_i    = tbl[i].addr;
      outport_accept_i = tbl[i].acc;
      tick();
      chk($sformatf("tbl%0d_accept", i), inport_accept_o, tbl[i].e_accept);
      chk($sformatf("tbl%0d_wr", i), outport_wr_o, tbl[i].e_wr);
      chk($sformatf("tbl%0d_rd", i), outport_rd_o, tbl[i].e_rd);
      if (tbl[i].e_wr != 0 || tbl[i].e_rd)
        chk($sformatf("tbl%0d_addr", i), outport_addr_o, tbl[i].e_addr);
    end

    // outstanding cap
    do_reset();
    outport_accept_i = 1'b1;
    inport_rd_i      = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (inport_accept_o) n++;
      tick();
    end
    chk("cap_count", n, 8);
    chk("cap_accept_low", inport_accept_o, 1'b0);
    outport_ack_i = 1'b1;
    tick();
    outport_ack_i = 1'b0;
    chk("cap_reopen", inport_accept_o, 1'b1);
    if (inport_accept_o) n++;
    tick();
    chk("cap_count9", n, 9);
    chk("cap_closed", inport_accept_o, 1'b0);

    // mid-burst reset: 3 queued, 2 outstanding
    do_reset();
    for (int i = 0; i < 3; i++) begin
      inport_wr_i   = 16'hFFFF;
      inport_addr_i = 32'h1000 + 32'(i * 16);
      tick();
    end
    inport_wr_i   = '0;
    outport_ack_i = 1'b1;
    tick();
    chk("mid_pre_wr", outport_wr_o, 16'hFFFF);
    rst_i = 1'b1;
    tick();
    rst_i         = 1'b0;
    outport_ack_i = 1'b0;
    chk("mid_wr", outport_wr_o, 16'h0);
    chk("mid_rd", outport_rd_o, 1'b0);
    chk("mid_ack", inport_ack_o, 1'b0);
    chk("mid_accept", inport_accept_o, 1'b1);
    outport_accept_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_stale", {outport_wr_o, outport_rd_o}, 17'h0);
    end

    // randomized run against a queue model
    do_reset();
    mq.delete();
    mout   = 0;
    p_ack  = 0;
    p_err  = 0;
    p_data = '0;
    p_id   = '0;
    for (int i = 0; i < 900; i++) begin
      exp_acc = (mq.size() < DEPTH) && (mout < MAXO);
      chk("rnd_accept", inport_accept_o, exp_acc);
      if (mq.size() == 0) begin
        chk("rnd_empty", {outport_wr_o, outport_rd_o}, 17'h0);
      end else begin
        chk("rnd_wr", outport_wr_o, mq[0].wr);
        chk("rnd_rd", outport_rd_o, mq[0].rd);
        chk("rnd_addr", outport_addr_o, mq[0].addr);
        chk("rnd_id", outport_req_id_o, mq[0].id);
        chk("rnd_wdata", outport_write_data_o, mq[0].data);
      end
      chk("rnd_ack", inport_ack_o, p_ack);
      chk("rnd_err", inport_error_o, p_err);
      chk("rnd_rdata", inport_read_data_o, p_data);
      chk("rnd_rid", inport_resp_id_o, p_id);

      acc_pct = (i < 300) ? 50 : (i < 600) ? 20 : 85;
      ack_pct = (i < 300) ? 30 : (i < 600) ? 10 : 60;
      present = ($urandom_range(0, 3) != 0);
      kind    = $urandom_range(0, 2);
      inport_wr_i = (present && kind > 0) ?
                    16'($urandom_range(1, 16'hFFFF)) : 16'h0;
      inport_rd_i = present && (kind != 1);
      inport_addr_i       = $urandom() & 32'hFFFF_FFF0;
      inport_write_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      inport_req_id_i     = 16'($urandom());
      outport_accept_i    = ($urandom_range(0, 99) < acc_pct);
      outport_ack_i       = (mout > 0) && ($urandom_range(0, 99) < ack_pct);
      outport_error_i     = 1'($urandom());
      outport_read_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      outport_resp_id_i   = 16'($urandom());

      xfer = present && exp_acc;
      if (outport_accept_i && mq.size() > 0) void'(mq.pop_front());
      if (xfer) begin
        e.addr = inport_addr_i;
        e.wr   = inport_wr_i;
        e.rd   = inport_rd_i && (inport_wr_i == 0);
        e.id   = inport_req_id_i;
        e.data = inport_write_data_i;
        mq.push_back(e);
      end
      if (xfer && !outport_ack_i) mout++;
      else if (!xfer && outport_ack_i && mout > 0) mout--;
      p_ack  = outport_ack_i;
      p_err  = outport_error_i;
      p_data = outport_read_data_i;
      p_id   = outport_resp_id_i;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
